// File: rtl/dilithium_lr_sequencer.sv
// ============================================================================
// Module   : dilithium_lr_sequencer
// Purpose  : Host-side sequencer for the low-resource Dilithium core; steps a
//            per-mode opcode program and meters payload words to/from the core.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dilithium_lr_sequencer #(
  parameter int DATA_W     = 32,
  parameter int SEED_WORDS = 8,
  parameter int PK_WORDS   = 328,
  parameter int SK_WORDS   = 640,
  parameter int SIG_WORDS  = 605,
  parameter int MSG_LEN_W  = 16,
  parameter int TIMEOUT_W  = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [MSG_LEN_W-1:0] msg_words,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 result,
  input  logic                 valid_i,
  output logic                 ready_i,
  input  logic [DATA_W-1:0]    data_i,
  output logic                 valid_o,
  input  logic                 ready_o,
  output logic [DATA_W-1:0]    data_o,
  output logic [3:0]           op_in,
  output logic                 op_valid_in,
  input  logic                 ready_out,
  output logic [DATA_W-1:0]    data_in,
  output logic                 valid_in,
  input  logic                 ready_rcv_out,
  input  logic [DATA_W-1:0]    data_out,
  input  logic                 valid_out,
  output logic                 ready_rcv_in
);

  localparam int MAX_A   = (SEED_WORDS > PK_WORDS) ? SEED_WORDS : PK_WORDS;
  localparam int MAX_B   = (SK_WORDS > SIG_WORDS) ? SK_WORDS : SIG_WORDS;
  localparam int MAX_FIX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_FIX + 1);
  localparam int LEN_W   = (CNT_W > MSG_LEN_W) ? CNT_W : MSG_LEN_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_GUARD  = 3'd2;
  localparam logic [2:0] S_XFER   = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [1:0] K_INGEST = 2'd0;
  localparam logic [1:0] K_EXEC   = 2'd1;
  localparam logic [1:0] K_DUMP   = 2'd2;

  localparam logic [1:0] M_KEYGEN  = 2'd0;
  localparam logic [1:0] M_VERIFY  = 2'd1;
  localparam logic [1:0] M_ILLEGAL = 2'd3;

  logic [2:0]           r_state;
  logic [1:0]           r_mode;
  logic [MSG_LEN_W-1:0] r_msg;
  logic [2:0]           r_step;
  logic [LEN_W-1:0]     r_cnt;
  logic [TIMEOUT_W-1:0] r_wdog;
  logic                 r_busy;
  logic                 r_error;
  logic                 r_result;

  logic [3:0]       w_op;
  logic [1:0]       w_kind;
  logic [LEN_W-1:0] w_len;
  logic             w_last;
  logic [2:0]       w_adv_state;
  logic [2:0]       w_nstate;
  logic             w_issue;
  logic             w_xin;
  logic             w_xout;
  logic             w_rslt;
  logic             w_count_st;
  logic             w_timeout;
  logic             w_op_acc;
  logic             w_hs;
  logic             w_res_hs;
  logic             w_cnt_last;

  // Per-mode micro-program: opcode, transfer kind and word count of each step.
  always_comb begin
    w_op   = 4'b0000;
    w_kind = K_EXEC;
    w_len  = '0;
    case (r_mode)
      M_KEYGEN: begin
        case (r_step)
          3'd0:    begin w_op = 4'b1111; w_kind = K_INGEST; w_len = LEN_W'(SEED_WORDS); end
          3'd1:    begin w_op = 4'b0111; end
          3'd2:    begin w_op = 4'b1001; w_kind = K_DUMP;   w_len = LEN_W'(SK_WORDS);   end
          default: begin w_op = 4'b1000; w_kind = K_DUMP;   w_len = LEN_W'(PK_WORDS);   end
        endcase
      end
      M_VERIFY: begin
        case (r_step)
          3'd0:    begin w_op = 4'b1100; w_kind = K_INGEST; w_len = LEN_W'(PK_WORDS);  end
          3'd1:    begin w_op = 4'b0101; end
          3'd2:    begin w_op = 4'b0001; w_kind = K_INGEST; w_len = LEN_W'(r_msg);     end
          3'd3:    begin w_op = 4'b1110; w_kind = K_INGEST; w_len = LEN_W'(SIG_WORDS); end
          default: begin w_op = 4'b0100; end
        endcase
      end
      default: begin
        case (r_step)
          3'd0:    begin w_op = 4'b1101; w_kind = K_INGEST; w_len = LEN_W'(SK_WORDS);  end
          3'd1:    begin w_op = 4'b0011; end
          3'd2:    begin w_op = 4'b0001; w_kind = K_INGEST; w_len = LEN_W'(r_msg);     end
          3'd3:    begin w_op = 4'b0010; end
          default: begin w_op = 4'b1010; w_kind = K_DUMP;   w_len = LEN_W'(SIG_WORDS); end
        endcase
      end
    endcase
  end

  assign w_last      = (r_mode == M_KEYGEN) ? (r_step == 3'd3) : (r_step == 3'd4);
  assign w_adv_state = !w_last ? S_ISSUE : ((r_mode == M_VERIFY) ? S_RESULT : S_FINISH);

  assign w_issue    = (r_state == S_ISSUE);
  assign w_xin      = (r_state == S_XFER) && (w_kind == K_INGEST);
  assign w_xout     = (r_state == S_XFER) && (w_kind == K_DUMP);
  assign w_rslt     = (r_state == S_RESULT);
  assign w_count_st = w_issue || (r_state == S_XFER) || w_rslt || (r_state == S_FINISH);
  assign w_timeout  = w_count_st && (&r_wdog);

  assign w_op_acc   = w_issue && ready_out && !w_timeout;
  assign w_hs       = (w_xin && valid_i && ready_rcv_out) || (w_xout && valid_out && ready_o);
  assign w_res_hs   = w_rslt && valid_out;
  assign w_cnt_last = ((r_cnt + LEN_W'(1)) == w_len);

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE:   if (start) w_nstate = (mode == M_ILLEGAL) ? S_DONE : S_ISSUE;
      S_ISSUE:  if (w_timeout) w_nstate = S_DONE;
                else if (w_op_acc) w_nstate = S_GUARD;
      S_GUARD:  w_nstate = ((w_kind != K_EXEC) && (w_len != '0)) ? S_XFER : w_adv_state;
      S_XFER:   if (w_timeout) w_nstate = S_DONE;
                else if (w_hs && w_cnt_last) w_nstate = w_adv_state;
      S_RESULT: if (w_timeout) w_nstate = S_DONE;
                else if (w_res_hs) w_nstate = S_FINISH;
      S_FINISH: if (w_timeout || ready_out) w_nstate = S_DONE;
      S_DONE:   w_nstate = S_IDLE;
      default:  w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_mode   <= 2'd0;
      r_msg    <= '0;
      r_step   <= 3'd0;
      r_cnt    <= '0;
      r_wdog   <= '0;
      r_busy   <= 1'b0;
      r_error  <= 1'b0;
      r_result <= 1'b0;
    end else begin
      r_state <= w_nstate;

      // Watchdog measures only stalls: any progress or state change restarts it.
      if ((w_nstate != r_state) || w_op_acc || w_hs || w_res_hs)
        r_wdog <= '0;
      else if (w_count_st)
        r_wdog <= r_wdog + TIMEOUT_W'(1);

      if ((r_state == S_IDLE) && start) begin
        r_mode   <= mode;
        r_msg    <= msg_words;
        r_step   <= 3'd0;
        r_error  <= (mode == M_ILLEGAL);
        r_result <= 1'b0;
        r_busy   <= (mode != M_ILLEGAL);
      end

      if (((r_state == S_GUARD) || (r_state == S_XFER)) && (w_nstate == S_ISSUE))
        r_step <= r_step + 3'd1;

      if (r_state == S_GUARD)
        r_cnt <= '0;
      else if (w_hs)
        r_cnt <= r_cnt + LEN_W'(1);

      if (w_res_hs && !w_timeout)
        r_result <= data_out[0];

      if (w_timeout) begin
        r_error  <= 1'b1;
        r_result <= 1'b0;
      end

      if (r_state == S_DONE)
        r_busy <= 1'b0;
    end
  end

  assign op_in        = w_issue ? w_op : 4'b0000;
  assign op_valid_in  = w_issue && ready_out && !w_timeout;
  assign valid_in     = w_xin && valid_i;
  assign ready_i      = w_xin && ready_rcv_out;
  assign valid_o      = w_xout && valid_out;
  assign ready_rcv_in = (w_xout && ready_o) || w_rslt;
  // Data paths are gated only by reset so every output reads zero while held.
  assign data_in      = rst_n ? data_i : '0;
  assign data_o       = rst_n ? data_out : '0;

  assign busy   = r_busy;
  assign done   = (r_state == S_DONE);
  assign error  = r_error;
  assign result = r_result;

endmodule

`default_nettype wire
